// File: rtl/accumulator_nbit.sv
`default_nettype none
// ============================================================================
//  Module      : accumulator_nbit (with helper adder_nbit)
//  Description : Streaming frame accumulator. Sums NUM_SAMPLES unsigned
//                samples received over a valid/ready handshake and presents
//                the wrapped sum plus a sticky carry-out flag downstream.
//  Revision    : 1.0 - initial release
// ============================================================================

// Unsigned N-bit adder with carry-in; overflow is the carry-out.
module adder_nbit #(
    parameter int BIT_WIDTH = 4
) (
    input  logic [BIT_WIDTH-1:0] a,
    input  logic [BIT_WIDTH-1:0] b,
    input  logic                 carry_in,
    output logic [BIT_WIDTH-1:0] sum,
    output logic                 overflow
);

    // Widen by one bit so the carry-out lands in the top bit.
    assign {overflow, sum} = {1'b0, a} + {1'b0, b} + {{BIT_WIDTH{1'b0}}, carry_in};

endmodule

module accumulator_nbit #(
    parameter int BIT_WIDTH   = 4,
    parameter int NUM_SAMPLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BIT_WIDTH-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BIT_WIDTH-1:0] out_sum,
    output logic                 out_overflow
);

    localparam int CNT_W = $clog2(NUM_SAMPLES + 1);

    // Count value held just before the accept that completes a frame.
    localparam logic [CNT_W-1:0] C_LAST_COUNT = CNT_W'(NUM_SAMPLES - 1);

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    state_t               state_q,  state_d;
    logic [BIT_WIDTH-1:0] acc_q,    acc_d;
    logic                 sticky_q, sticky_d;
    logic [CNT_W-1:0]     count_q,  count_d;

    logic [BIT_WIDTH-1:0] add_sum;
    logic                 add_ovf;

    adder_nbit #(
        .BIT_WIDTH (BIT_WIDTH)
    ) u_adder (
        .a        (acc_q),
        .b        (in_data),
        .carry_in (1'b0),
        .sum      (add_sum),
        .overflow (add_ovf)
    );

    // Next-state logic: clear outranks normal operation; HOLD ignores samples.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        sticky_d = sticky_q;
        count_d  = count_q;

        if (clear) begin
            state_d  = ST_ACCUM;
            acc_d    = '0;
            sticky_d = 1'b0;
            count_d  = '0;
        end else begin
            case (state_q)
                ST_ACCUM: begin
                    if (in_valid) begin
                        acc_d    = add_sum;
                        sticky_d = sticky_q | add_ovf;
                        count_d  = count_q + CNT_W'(1);
                        if (count_q == C_LAST_COUNT) begin
                            state_d = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        state_d  = ST_ACCUM;
                        acc_d    = '0;
                        sticky_d = 1'b0;
                        count_d  = '0;
                    end
                end
                default: begin
                    state_d = ST_ACCUM;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_ACCUM;
            acc_q    <= '0;
            sticky_q <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            sticky_q <= sticky_d;
            count_q  <= count_d;
        end
    end

    // Handshake flags come from registered state only; data straight from registers.
    always_comb begin
        in_ready     = (state_q == ST_ACCUM);
        out_valid    = (state_q == ST_HOLD);
        out_sum      = acc_q;
        out_overflow = sticky_q;
    end

endmodule
`default_nettype wire
